// File: rtl/wb_counter_bank_pkg.sv
// -----------------------------------------------------------------------------
// wb_counter_bank_pkg
// Shared definitions for the Wishbone counter bank:
//   - register offsets within a channel's 16-byte window (adr[3:2])
//   - CTRL bit positions
//   - logic-analyser bit bases (freeze inputs, match observe outputs)
//   - the captured Wishbone request record and a byte-lane merge helper
// Optional feature macro used by the design files: WB_COUNTER_BANK_PRESCALE_EN
// -----------------------------------------------------------------------------
package wb_counter_bank_pkg;

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_COUNT   = 2'd1,
    REG_COMPARE = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_DOWN_BIT  = 1;
  localparam int CTRL_AR_BIT    = 2;
  localparam int CTRL_IE_BIT    = 3;
  localparam int CTRL_PRESC_LSB = 8;

  localparam int LA_FREEZE_BASE = 64;
  localparam int LA_MATCH_BASE  = 32;

  // Request captured on the accepting cycle and committed on the ack cycle.
  typedef struct packed {
    logic        we;
    logic [3:0]  ch;
    reg_sel_e    rsel;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  localparam wb_req_t REQ_IDLE = '{we: 1'b0, ch: 4'd0, rsel: REG_CTRL, sel: 4'd0, dat: 32'd0};

  // Replace the bytes of old_v selected by sel with the matching bytes of new_v.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_counter_bank_channel.sv
// -----------------------------------------------------------------------------
// wb_counter_channel
// One counter channel: CTRL / COUNT / COMPARE / MATCH state plus its counting.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wr_en_i             a write to this channel commits this cycle
//   wr_reg_i/sel/dat    target register, byte lanes and data of that write
//   rd_reg_i            register selected for read-back (rd_dat_o, combinational)
//   freeze_i            hold the counter (and prescaler) this cycle
//   count_o             current COUNT
//   match_o             sticky MATCH flag
//   irq_src_o           MATCH & IE
// Macro WB_COUNTER_BANK_PRESCALE_EN adds an 8-bit prescaler in CTRL[15:8].
// -----------------------------------------------------------------------------
module wb_counter_channel
  import wb_counter_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  reg_sel_e         wr_reg_i,
  input  logic [3:0]       wr_sel_i,
  input  logic [31:0]      wr_dat_i,
  input  reg_sel_e         rd_reg_i,
  input  logic             freeze_i,
  output logic [31:0]      rd_dat_o,
  output logic [WIDTH-1:0] count_o,
  output logic             match_o,
  output logic             irq_src_o
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             en_q, en_d, down_q, down_d, ar_q, ar_d, ie_q, ie_d;
  logic [WIDTH-1:0] count_q, count_d, compare_q, compare_d;
  logic             match_q, match_d;
  logic [7:0]       presc_s;
  logic             wr_ctrl_s, wr_count_s, wr_compare_s, wr_status_s;
  logic [31:0]      ctrl_rd_s, count_ext_s, compare_ext_s;
  logic [31:0]      ctrl_new_s, count_new_s, compare_new_s;
  logic             run_s, tick_s, step_s, match_set_s, w1c_s;
  logic             ch_unused_s;

`ifdef WB_COUNTER_BANK_PRESCALE_EN
  logic [7:0] presc_q, presc_d, psc_cnt_q, psc_cnt_d;
`endif

  assign count_ext_s   = 32'(count_q);
  assign compare_ext_s = 32'(compare_q);
  assign ctrl_rd_s     = {16'd0, presc_s, 4'd0, ie_q, ar_q, down_q, en_q};

  assign ctrl_new_s    = merge_bytes(ctrl_rd_s, wr_dat_i, wr_sel_i);
  assign count_new_s   = merge_bytes(count_ext_s, wr_dat_i, wr_sel_i);
  assign compare_new_s = merge_bytes(compare_ext_s, wr_dat_i, wr_sel_i);
  assign ch_unused_s   = ^{ctrl_new_s[31:4], count_new_s, compare_new_s};

  // Decode which register a committing write targets
  always_comb begin
    wr_ctrl_s    = 1'b0;
    wr_count_s   = 1'b0;
    wr_compare_s = 1'b0;
    wr_status_s  = 1'b0;
    case (wr_reg_i)
      REG_CTRL:    wr_ctrl_s    = wr_en_i;
      REG_COUNT:   wr_count_s   = wr_en_i;
      REG_COMPARE: wr_compare_s = wr_en_i;
      REG_STATUS:  wr_status_s  = wr_en_i;
      default:     wr_ctrl_s    = 1'b0;
    endcase
  end

  assign run_s = en_q & ~freeze_i;
  assign w1c_s = wr_status_s & wr_sel_i[0] & wr_dat_i[0];

`ifdef WB_COUNTER_BANK_PRESCALE_EN
  // Prescaler: counts enabled unfrozen cycles, ticks every PRESC+1 of them.
  // EN can only rise through a CTRL write, so clearing on any CTRL write also
  // covers the EN 0->1 restart.
  always_comb begin
    presc_s   = presc_q;
    tick_s    = (psc_cnt_q == presc_q);
    psc_cnt_d = psc_cnt_q;
    presc_d   = presc_q;
    if (wr_ctrl_s) begin
      psc_cnt_d = 8'd0;
      presc_d   = ctrl_new_s[CTRL_PRESC_LSB +: 8];
    end else if (run_s) begin
      psc_cnt_d = tick_s ? 8'd0 : psc_cnt_q + 8'd1;
    end else begin
      psc_cnt_d = psc_cnt_q;
    end
  end
`else
  assign presc_s = 8'd0;
  assign tick_s  = 1'b1;
`endif

  assign step_s = run_s & tick_s;

  // Next COUNT / MATCH: a COUNT write overrides the advance entirely
  always_comb begin
    count_d     = count_q;
    match_set_s = 1'b0;
    if (wr_count_s) begin
      count_d = count_new_s[WIDTH-1:0];
    end else if (step_s) begin
      if (down_q) begin
        if (count_q == CNT_ZERO) begin
          match_set_s = 1'b1;
          count_d     = ar_q ? compare_q : CNT_ONES;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end else begin
        if (count_q == compare_q) begin
          match_set_s = 1'b1;
          count_d     = ar_q ? CNT_ZERO : count_q + CNT_ONE;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
    end else begin
      count_d = count_q;
    end
    // A match set in the same cycle as a W1C keeps the flag high.
    match_d = match_set_s ? 1'b1 : (w1c_s ? 1'b0 : match_q);
  end

  // Next CTRL and COMPARE
  always_comb begin
    en_d      = en_q;
    down_d    = down_q;
    ar_d      = ar_q;
    ie_d      = ie_q;
    compare_d = compare_q;
    if (wr_ctrl_s) begin
      en_d   = ctrl_new_s[CTRL_EN_BIT];
      down_d = ctrl_new_s[CTRL_DOWN_BIT];
      ar_d   = ctrl_new_s[CTRL_AR_BIT];
      ie_d   = ctrl_new_s[CTRL_IE_BIT];
    end else begin
      en_d = en_q;
    end
    if (wr_compare_s) begin
      compare_d = compare_new_s[WIDTH-1:0];
    end else begin
      compare_d = compare_q;
    end
  end

  // Channel state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q      <= 1'b0;
      down_q    <= 1'b0;
      ar_q      <= 1'b0;
      ie_q      <= 1'b0;
      count_q   <= CNT_ZERO;
      compare_q <= CNT_ZERO;
      match_q   <= 1'b0;
`ifdef WB_COUNTER_BANK_PRESCALE_EN
      presc_q   <= 8'd0;
      psc_cnt_q <= 8'd0;
`endif
    end else begin
      en_q      <= en_d;
      down_q    <= down_d;
      ar_q      <= ar_d;
      ie_q      <= ie_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
`ifdef WB_COUNTER_BANK_PRESCALE_EN
      presc_q   <= presc_d;
      psc_cnt_q <= psc_cnt_d;
`endif
    end
  end

  // Read-back mux for the register selected by the live bus address
  always_comb begin
    rd_dat_o = 32'd0;
    case (rd_reg_i)
      REG_CTRL:    rd_dat_o = ctrl_rd_s;
      REG_COUNT:   rd_dat_o = count_ext_s;
      REG_COMPARE: rd_dat_o = compare_ext_s;
      REG_STATUS:  rd_dat_o = {31'd0, match_q};
      default:     rd_dat_o = 32'd0;
    endcase
  end

  assign count_o   = count_q;
  assign match_o   = match_q;
  assign irq_src_o = match_q & ie_q;

endmodule

// File: rtl/wb_counter_bank.sv
// -----------------------------------------------------------------------------
// wb_counter_bank
// Wishbone slave exposing NUM_CH independent WIDTH-bit counters.
// Each channel owns a 16-byte window: adr[7:4] = channel, adr[3:2] = register.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wbs_*                       Wishbone slave (single-cycle ack after a hit)
//   la_data_in / la_oenb        LA inputs; bit 64+ch freezes channel ch
//   la_data_out                 [31:0] ch0 COUNT, [32+ch] MATCH of ch, rest 0
//   irq                         [0] registered OR of MATCH & IE, [2:1] = 0
// Optional macro: WB_COUNTER_BANK_PRESCALE_EN (per-channel prescaler).
// -----------------------------------------------------------------------------
module wb_counter_bank
  import wb_counter_bank_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_dat_i,
  input  logic [31:0]  wbs_adr_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  input  logic [127:0] la_data_in,
  output logic [127:0] la_data_out,
  input  logic [127:0] la_oenb,
  output logic [2:0]   irq
);

  logic                         hit_s, accept_s;
  logic                         ack_q, ack_d;
  logic [31:0]                  dat_q, dat_d;
  wb_req_t                      req_q, req_d;
  logic [3:0]                   adr_ch_s;
  reg_sel_e                     adr_reg_s;
  logic [31:0]                  rd_data_s;
  logic [NUM_CH-1:0][31:0]      rd_a;
  logic [NUM_CH-1:0][WIDTH-1:0] count_a;
  logic [NUM_CH-1:0]            wr_en_s, freeze_s, match_s, irq_src_s;
  logic                         irq_q;
  logic [127:0]                 la_out_s;
  logic                         bus_unused_s;

  assign hit_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // A hit during the ack cycle is ignored, so every transfer takes >= 2 cycles.
  assign accept_s  = hit_s & ~ack_q;
  assign adr_ch_s  = wbs_adr_i[7:4];
  assign adr_reg_s = reg_sel_e'(wbs_adr_i[3:2]);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [3:0] CH_IDX = 4'(g);
    // Writes to channels >= NUM_CH match no instance and are dropped.
    assign wr_en_s[g]  = ack_q & req_q.we & (req_q.ch == CH_IDX);
    assign freeze_s[g] = ~la_oenb[LA_FREEZE_BASE + g] & la_data_in[LA_FREEZE_BASE + g];

    wb_counter_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i     (wb_clk_i),
      .rst_i     (wb_rst_i),
      .wr_en_i   (wr_en_s[g]),
      .wr_reg_i  (req_q.rsel),
      .wr_sel_i  (req_q.sel),
      .wr_dat_i  (req_q.dat),
      .rd_reg_i  (adr_reg_s),
      .freeze_i  (freeze_s[g]),
      .rd_dat_o  (rd_a[g]),
      .count_o   (count_a[g]),
      .match_o   (match_s[g]),
      .irq_src_o (irq_src_s[g])
    );
  end

  // Select read data for the addressed channel; unpopulated channels read 0
  always_comb begin
    rd_data_s = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_data_s = rd_data_s | ((adr_ch_s == 4'(i)) ? rd_a[i] : 32'd0);
    end
  end

  // Next ack, read data and captured request
  always_comb begin
    ack_d = accept_s;
    dat_d = (accept_s & ~wbs_we_i) ? rd_data_s : 32'd0;
    if (accept_s) begin
      req_d = '{we: wbs_we_i, ch: adr_ch_s, rsel: adr_reg_s, sel: wbs_sel_i, dat: wbs_dat_i};
    end else begin
      req_d = req_q;
    end
  end

  // Bus-side registers; reset drops any pending ack and its write
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= 32'd0;
      req_q <= REQ_IDLE;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      req_q <= req_d;
    end
  end

  // Interrupt output, one cycle behind the flags
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |irq_src_s;
    end
  end

  // LA observe word
  always_comb begin
    la_out_s                             = 128'd0;
    la_out_s[31:0]                       = 32'(count_a[0]);
    la_out_s[LA_MATCH_BASE +: NUM_CH]    = match_s;
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign la_data_out  = la_out_s;
  assign irq          = {2'b00, irq_q};
  assign bus_unused_s = ^{wbs_adr_i[1:0], la_data_in, la_oenb, count_a};

endmodule

// File: doc/wb_counter_bank.md
Name: wb_counter_bank

Overview:
- Parametrised successor to the single-counter user project: a Wishbone-slave bank of NUM_CH independent WIDTH-bit counters.
- Each counter supports up/down counting, compare match and auto-reload.
- Exposes logic-analyser freeze/observe hooks and a maskable match interrupt.
- Instantiated inside user_project_wrapper on the management Wishbone bus.

Parameters:
- NUM_CH, 4, number of counter channels (1..16).
- WIDTH, 32, counter width in bits (8..32).
- BASE_ADDR, 32'h3000_0000, block decodes when wbs_adr_i[31:8] == BASE_ADDR[31:8].

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte lane enables.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- la_data_in  in  128  LA input data.
- la_data_out  out  128  LA observe data.
- la_oenb  in  128  LA output-enable, active low.
- irq  out  3  interrupt lines.

Behaviour:
- Clocking/reset: one clock, wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values: all COUNT, COMPARE and CTRL registers, match flags, wbs_ack_o, wbs_dat_o and irq = 0.
- Decode: hit = cyc & stb & adr[31:8] match. Channel ch = adr[7:4]; reg = adr[3:2]; adr[1:0] ignored.
- Register map:
  - 0 CTRL: bit0 EN, bit1 DOWN, bit2 AUTORELOAD, bit3 IE.
  - 1 COUNT.
  - 2 COMPARE.
  - 3 STATUS: bit0 MATCH, sticky, write-1-to-clear.
- Handshake:
  - wbs_ack_o rises the cycle after a hit and stays high exactly one cycle.
  - A hit while ack is high is ignored; back-to-back transfers therefore take ≥2 cycles.
  - Writes commit on the ack cycle, honouring wbs_sel_i per byte.
  - Read data is valid with ack, zero-extended above WIDTH, and 0 elsewhere.
  - Non-hit: no ack, wbs_dat_o = 0.
  - ch >= NUM_CH: acked; reads return 0; writes are dropped.
- Counting advances when EN=1 and the channel is not frozen.
  - Up mode:
    - If COUNT==COMPARE: MATCH<=1, and COUNT <= AUTORELOAD ? 0 : COUNT+1.
    - Otherwise COUNT <= COUNT+1.
    - Wraps 2^WIDTH-1 → 0.
  - Down mode:
    - If COUNT==0: MATCH<=1, and COUNT <= AUTORELOAD ? COMPARE : all-ones.
    - Otherwise COUNT <= COUNT-1.
- Simultaneous events:
  - A Wishbone write to COUNT beats the advance in the same cycle.
  - A MATCH set beats a W1C in the same cycle (flag stays 1).
  - A CTRL write takes effect from the next cycle.
- LA freeze: channel ch is frozen when la_oenb[64+ch]==0 and la_data_in[64+ch]==1.
- LA observe:
  - la_data_out[31:0] = channel 0 COUNT, zero-extended.
  - la_data_out[32+ch] = MATCH of channel ch.
  - All other bits = 0.
- irq[0] = OR over channels of (MATCH & IE), registered (one-cycle latency from the flag). irq[2:1] = 0.
- Reset mid-transfer: ack is dropped and the pending write is discarded. The master must restart.

Optional Feature:
- Macro: WB_COUNTER_BANK_PRESCALE_EN.
- When defined:
  - CTRL[15:8] = PRESC, read/write.
  - A per-channel 8-bit prescaler counts enabled, unfrozen cycles; the counter advances once every PRESC+1 such cycles.
  - The prescaler resets to 0 on a CTRL write or an EN 0→1 transition.
- When undefined: CTRL[15:8] reads 0 and writes are ignored; the counter advances every enabled cycle.

Decomposition:
- Package wb_counter_bank_pkg:
  - register offset constants (REG_CTRL=0, REG_COUNT=1, REG_COMPARE=2, REG_STATUS=3);
  - CTRL bit-position constants;
  - LA bit-base constants (64 freeze, 32 match).
- Sub-module wb_counter_channel: one channel holding its CTRL/COUNT/COMPARE/MATCH state and counting logic. The top generates NUM_CH instances plus the Wishbone decode/ack and the irq/LA muxing.

Test Plan:
- Reset, then read all registers of ch0..3 → all 0, each ack exactly 1 cycle after stb.
- ch1 COMPARE=5, CTRL=0x9 (EN|IE):
  - MATCH sets on the cycle COUNT==5, and irq[0] follows one cycle later.
  - Write STATUS=1 → irq[0] drops; COUNT keeps going 6, 7, …
- ch2 DOWN|AUTORELOAD, COMPARE=3, COUNT=1 → sequence 1, 0, 3, 2, 1, 0, 3 with MATCH set at each 0.
- Collision checks:
  - ch0 up with a COUNT=0x100 write landing on an increment cycle → next COUNT 0x100, then 0x101.
  - W1C on the match cycle → MATCH stays 1.
- LA: la_oenb[64]=0, la_data_in[64]=1 → ch0 COUNT holds while la_data_out[31:0] shows the held value; release → counting resumes.
- With WB_COUNTER_BANK_PRESCALE_EN, PRESC=3 → COUNT increments every 4 cycles. With ch=7 on NUM_CH=4 → read 0, ack present.
